// File: rtl/fpu_pkg.sv
// Shared constants, flag bit positions and sequencer state encoding for the FPU divide path.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam int          FP_BIAS    = 127;

    localparam int FLG_INV = 3;
    localparam int FLG_DZ  = 2;
    localparam int FLG_OF  = 1;
    localparam int FLG_UF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, FP_EXP_MAX, 23'h000000};
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'h0000_0000};
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Single-precision operand classifier; denormals (exponent 0) are reported as zero.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [30:0] op,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    assign is_zero = (op[30:23] == 8'h00);
    assign is_inf  = (op[30:23] == FP_EXP_MAX) && (op[22:0] == 23'h000000);
    assign is_nan  = (op[30:23] == FP_EXP_MAX) && (op[22:0] != 23'h000000);

endmodule

// File: rtl/fpu_div_sequencer.sv
// Issue/capture controller in front of the combinational divider: resolves special operands,
// holds operands for SETTLE_CYCLES edges, then range-corrects the quotient. Flags need FPU_DIV_FLAGS_EN.
module fpu_div_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;

    logic a_zero_s, a_inf_s, a_nan_s;
    logic b_zero_s, b_inf_s, b_nan_s;
    logic in_sign_s, cap_sign_s;
    logic spec_s;
    logic [31:0] spec_res_s;
    logic signed [9:0] e_s;
    logic cap_of_s, cap_uf_s;
    logic [31:0] cap_res_s;

    fpu_classify u_cls_a (.op(in_a[30:0]), .is_zero(a_zero_s), .is_inf(a_inf_s), .is_nan(a_nan_s));
    fpu_classify u_cls_b (.op(in_b[30:0]), .is_zero(b_zero_s), .is_inf(b_inf_s), .is_nan(b_nan_s));

    assign in_sign_s  = in_a[31] ^ in_b[31];
    assign cap_sign_s = div_a_q[31] ^ div_b_q[31];

    // Special-operand resolution in priority order; spec_s low means the divider is needed.
    always_comb begin
        spec_s     = 1'b1;
        spec_res_s = FP_QNAN;
        if (a_nan_s || b_nan_s) begin
            spec_res_s = FP_QNAN;
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_res_s = FP_QNAN;
        end else if (a_inf_s || b_zero_s) begin
            spec_res_s = fp_inf(in_sign_s);
        end else if (a_zero_s || b_inf_s) begin
            spec_res_s = fp_zero(in_sign_s);
        end else begin
            spec_s     = 1'b0;
            spec_res_s = FP_QNAN;
        end
    end

    // Biased quotient exponent; the mantissa ratio lies in (0.5, 2), so only e==255/e==1 need ma vs mb.
    always_comb begin
        e_s      = $signed({2'b00, div_a_q[30:23]}) - $signed({2'b00, div_b_q[30:23]}) + 10'sd127;
        cap_of_s = (e_s >= 10'sd256) || ((e_s == 10'sd255) && (div_a_q[22:0] >= div_b_q[22:0]));
        cap_uf_s = (e_s <= 10'sd0)   || ((e_s == 10'sd1)   && (div_a_q[22:0] <  div_b_q[22:0]));
        if (cap_of_s) begin
            cap_res_s = fp_inf(cap_sign_s);
        end else if (cap_uf_s) begin
            cap_res_s = fp_zero(cap_sign_s);
        end else begin
            cap_res_s = div_result;
        end
    end

    // Next-state and output-register logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    div_a_d = in_a;
                    div_b_d = in_b;
                    if (spec_s) begin
                        state_d      = ST_DONE;
                        out_valid_d  = 1'b1;
                        out_result_d = spec_res_s;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d      = ST_DONE;
                    out_valid_d  = 1'b1;
                    out_result_d = cap_res_s;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            div_a_q      <= 32'h0000_0000;
            div_b_q      <= 32'h0000_0000;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

`ifdef FPU_DIV_FLAGS_EN
    logic [3:0] spec_flg_s;
    logic [3:0] flags_q, flags_d;

    // Flag for the special path, same priority as the result selection.
    always_comb begin
        spec_flg_s = 4'b0000;
        if (a_nan_s || b_nan_s) begin
            spec_flg_s = 4'b0000;
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_flg_s[FLG_INV] = 1'b1;
        end else if (a_inf_s) begin
            spec_flg_s = 4'b0000;
        end else if (b_zero_s) begin
            spec_flg_s[FLG_DZ] = 1'b1;
        end else begin
            spec_flg_s = 4'b0000;
        end
    end

    // Flags are loaded alongside out_result and otherwise held.
    always_comb begin
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    flags_d = spec_flg_s;
                end else begin
                    flags_d = flags_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    flags_d         = 4'b0000;
                    flags_d[FLG_OF] = cap_of_s;
                    flags_d[FLG_UF] = cap_uf_s;
                end else begin
                    flags_d = flags_q;
                end
            end
            default: flags_d = flags_q;
        endcase
    end

    // Flag register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 4'b0000;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: doc/fpu_div_sequencer.md
# fpu_div_sequencer

- Multi-cycle issue/capture controller that sits directly upstream of the combinational single-precision divider in the FPU.
- Accepts an operand pair over a valid/ready handshake and resolves IEEE-754 special cases itself.
- For normal operands, holds registered operands stable on the divider inputs for a fixed settle window, then captures the quotient.
- Applies exponent overflow/underflow correction and presents the result over a valid/ready handshake.

## Interface

Parameters:
- SETTLE_CYCLES, 4, clock edges operands are held before divider output is captured; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept (combinational: state==IDLE)
- in_a  in  32  dividend, IEEE-754 single
- in_b  in  32  divisor, IEEE-754 single
- div_a  out  32  registered dividend to divider
- div_b  out  32  registered divisor to divider
- div_result  in  32  divider quotient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  quotient
- out_flags  out  4  {invalid, div_by_zero, overflow, underflow}

## Operation

- States:
  - IDLE: accept on in_valid & in_ready.
  - WAIT: count the settle window.
  - DONE: present result until out_valid & out_ready, then go to IDLE.
- On accept:
  - in_a/in_b are registered into div_a/div_b.
  - Both operands are classified: zero = exp 0 (denormals flushed to zero), inf = exp 255 with mantissa 0, nan = exp 255 with mantissa ≠ 0.
- Special cases go IDLE→DONE directly. Sign s = a[31]^b[31]. Priority order:
  1. Either operand NaN → 32'h7FC0_0000, no flag.
  2. 0/0 or inf/inf → 32'h7FC0_0000, invalid.
  3. inf/x → {s, 8'hFF, 23'h0}.
  4. x/0 (x finite nonzero) → {s, 8'hFF, 23'h0}, div_by_zero.
  5. 0/x or x/inf → {s, 31'h0}.
- Normal path: IDLE→WAIT, counter loaded with SETTLE_CYCLES-1.
  - Each WAIT edge: if the counter is 0, capture and go to DONE; otherwise decrement.
- Exponent check at capture, with e = ea - eb + 127 as a 10-bit signed value and ma/mb the 23-bit mantissa fields:
  - Overflow → {s, 8'hFF, 23'h0} with overflow flag, when e ≥ 256, or e == 255 and ma ≥ mb.
  - Underflow → {s, 31'h0} with underflow flag, when e ≤ 0, or e == 1 and ma < mb.
  - Otherwise out_result = div_result.
- No overlap: in_ready stays low in WAIT and DONE. in_valid in those states is ignored.

## Timing

- Reset (asynchronous, any state):
  - State → IDLE.
  - out_valid, out_result, out_flags, div_a, div_b, counter → 0.
  - in_ready reads 1 while reset is asserted.
  - An in-flight operation is discarded.
- Normal latency: out_valid rises after edge SETTLE_CYCLES counted from the accept edge (edge 0).
- Special-case latency: out_valid high after the accept edge itself.
- DONE:
  - out_result and out_flags are stable while out_valid & !out_ready.
  - The handshake edge returns to IDLE.
  - in_ready is high the following cycle.
- Throughput: one operation per SETTLE_CYCLES+2 cycles minimum (normal path), 2 cycles (special path).
- div_a/div_b change only on accept edges.

## Configuration

- FPU_DIV_FLAGS_EN defined: flag generation as above.
- Undefined:
  - out_flags port remains, driven constant 4'b0000.
  - Flag registers are not synthesized.
  - Result values are unchanged.

## Structure

- Package fpu_pkg holds:
  - Constants: FP_QNAN = 32'h7FC0_0000, FP_EXP_MAX = 8'hFF, FP_BIAS = 127.
  - Flag bit indices: FLG_INV = 3, FLG_DZ = 2, FLG_OF = 1, FLG_UF = 0.
  - The sequencer state enum.
- One sub-module, fpu_classify: per-operand is_zero/is_inf/is_nan, instantiated twice.

## Test plan

- Scale: default SETTLE_CYCLES = 4, with a divider model that returns the true quotient.
  - 40C0_0000 / 4000_0000 (6/2) → out_result 4040_0000, flags 0.
  - out_valid high after edge 4 counted from the accept edge.
- Divide by zero: 3F80_0000 / 0000_0000 → 7F80_0000, div_by_zero, out_valid high one edge after accept.
- Invalid and infinity:
  - 0000_0000 / 8000_0000 → 7FC0_0000 with invalid.
  - FF80_0000 / 4000_0000 → FF80_0000, flags 0.
- Range:
  - 7F00_0000 / 0080_0000 → 7F80_0000 with overflow.
  - 0080_0000 / 7F00_0000 → 0000_0000 with underflow.
- Backpressure: hold out_ready low 5 cycles while pulsing in_valid with new operands → out_result stable, in_ready 0, new operands not accepted, div_a unchanged.
- Reset mid-WAIT: assert RESET_N low at counter 2 → out_valid 0 and in_ready 1 immediately; a subsequent 3F80_0000 / 4000_0000 yields 3F00_0000.
